// File: rtl/frame_packer.sv
// frame_packer: captures one frame from a handshaked 8-bit pixel source and
// packs four pixels per 32-bit word. Each word goes out on a valid/ready
// write port at consecutive word addresses starting at BASE_ADDR.
module frame_packer #(
    parameter int OUT_WIDTH  = 800,
    parameter int OUT_HEIGHT = 600,
    parameter int ADDR_W     = 20,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_go,
    output logic              busy,
    output logic              src_start,
    input  logic              src_start_ack,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [7:0]        src_pixel,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              frame_done
);

    localparam logic [18:0]       TOTAL_PIX = 19'(OUT_WIDTH * OUT_HEIGHT);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, REQ, REL, STREAM, DONE} state_t;

    state_t            state_reg, state_next;
    logic [18:0]       pix_cnt_reg;
    logic [ADDR_W-1:0] word_cnt_reg;
    logic [1:0]        lane_reg;
    logic              wr_valid_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [31:0]       wr_data_reg;
    logic              start_frame;
    logic              pix_xfer;
    logic              wr_accept;
    logic              slot_free;

    // The output slot can take a new word when empty or being emptied now.
    assign slot_free = !wr_valid_reg || wr_ready;
    assign pix_xfer  = src_valid && src_ready;
    assign wr_accept = wr_valid_reg && wr_ready;

    assign wr_valid = wr_valid_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state and control outputs, decoded from the current state.
    always_comb begin
        state_next  = state_reg;
        src_start   = 1'b0;
        src_ready   = 1'b0;
        frame_done  = 1'b0;
        start_frame = 1'b0;
        busy        = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (frame_go) begin
                    start_frame = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                src_start = 1'b1;
                if (src_start_ack) state_next = REL;
            end
            REL: begin
                // The source starts streaming once it sees start released.
                if (!src_start_ack) state_next = STREAM;
            end
            STREAM: begin
                src_ready = slot_free && (pix_cnt_reg < TOTAL_PIX);
                // All pixels taken and the final word leaving (or gone).
                if (pix_cnt_reg == TOTAL_PIX && slot_free) state_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding registers for lanes 0..2; lane 3 goes straight into the word.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] byte_reg;
        // Capture this lane's pixel when it is transferred.
        always_ff @(posedge clock or posedge reset) begin
            if (reset)                                   byte_reg <= '0;
            else if (pix_xfer && lane_reg == 2'(gi))     byte_reg <= src_pixel;
        end
    end

    // Counters and the write slot: load on lane-3 transfers, release on accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            lane_reg     <= '0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= BASE;
            wr_data_reg  <= '0;
        end else if (start_frame) begin
            pix_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            lane_reg     <= '0;
        end else begin
            if (wr_accept) word_cnt_reg <= word_cnt_reg + 1'b1;
            if (pix_xfer) begin
                pix_cnt_reg <= pix_cnt_reg + 19'd1;
                lane_reg    <= lane_reg + 2'd1;
            end
            if (pix_xfer && lane_reg == 2'd3) begin
                wr_valid_reg <= 1'b1;
                wr_data_reg  <= {src_pixel, g_lane[2].byte_reg,
                                 g_lane[1].byte_reg, g_lane[0].byte_reg};
                // A word accepted this same cycle already owns the current count.
                wr_addr_reg  <= BASE + word_cnt_reg
                                + {{(ADDR_W-1){1'b0}}, wr_accept};
            end else if (wr_accept) begin
                wr_valid_reg <= 1'b0;
            end
        end
    end

endmodule
